// File: rtl/i2c_txn_scheduler.sv
// Round-robin front end that turns requester transactions into START/ADDR/DATA/STOP
// commands for a shared byte-level I2C engine and reports done/error per requester.
module i2c_txn_scheduler #(
  parameter int N_REQ     = 2,
  parameter int MAX_BYTES = 2,
  parameter int LENW      = $clog2(MAX_BYTES + 1),
  parameter int TIMEOUT   = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0]             req_rw,
  input  logic [7*N_REQ-1:0]           req_addr,
  input  logic [LENW*N_REQ-1:0]        req_len,
  input  logic [8*MAX_BYTES*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             rsp_done,
  output logic [N_REQ-1:0]             rsp_err,
  output logic [8*MAX_BYTES-1:0]       rsp_rdata,
  output logic                         busy,
  output logic                         eng_cmd_valid,
  output logic [1:0]                   eng_cmd,
  output logic [7:0]                   eng_cmd_data,
  output logic                         eng_cmd_last,
  input  logic                         eng_cmd_ready,
  input  logic                         eng_rsp_valid,
  input  logic [7:0]                   eng_rsp_data,
  input  logic                         eng_rsp_nack
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = 8 * MAX_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  logic [2:0]       state_reg;
  logic             wait_reg;
  logic [IW-1:0]    ptr_reg;
  logic [N_REQ-1:0] gnt_reg;
  logic             rw_reg;
  logic [6:0]       addr_reg;
  logic [LENW-1:0]  len_reg;
  logic [LENW-1:0]  cnt_reg;
  logic [DW-1:0]    wdata_reg;
  logic [DW-1:0]    rdata_reg;
  logic             err_reg;
  logic [TW-1:0]    tmr_reg;

  logic [6:0]      addr_arr  [N_REQ];
  logic [LENW-1:0] len_arr   [N_REQ];
  logic [DW-1:0]   wdata_arr [N_REQ];
  logic [N_REQ-1:0] hi_req;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    idx_chain [N_REQ+1];
  logic [IW-1:0]    arb_idx;
  logic [LENW-1:0]  arb_len;
  logic [LENW-1:0]  cnt_inc;
  logic             xfer;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[7*gi +: 7];
      assign len_arr[gi]   = req_len[LENW*gi +: LENW];
      assign wdata_arr[gi] = req_wdata[DW*gi +: DW];
      assign hi_req[gi]    = req[gi] && (IW'(gi) > ptr_reg);
      assign idx_chain[gi+1] = idx_chain[gi] | (arb_oh[gi] ? IW'(gi) : '0);
    end
  endgenerate

  // Requests above the pointer win; otherwise wrap to the lowest set request.
  assign pick      = (|hi_req) ? hi_req : req;
  assign arb_oh    = pick & (~pick + N_REQ'(1));
  assign idx_chain[0] = '0;
  assign arb_idx   = idx_chain[N_REQ];
  assign arb_len   = (len_arr[arb_idx] > LENW'(MAX_BYTES)) ? LENW'(MAX_BYTES) : len_arr[arb_idx];
  assign cnt_inc   = cnt_reg + LENW'(1);
  assign xfer      = eng_cmd_valid && eng_cmd_ready;

  always_comb begin
    eng_cmd_valid = 1'b0;
    eng_cmd       = CMD_START;
    eng_cmd_data  = 8'h00;
    eng_cmd_last  = 1'b0;
    case (state_reg)
      ST_START: eng_cmd_valid = !wait_reg;
      ST_ADDR: begin
        eng_cmd_valid = !wait_reg;
        eng_cmd       = CMD_WRITE;
        eng_cmd_data  = {addr_reg, rw_reg};
      end
      ST_DATA: begin
        eng_cmd_valid = !wait_reg;
        if (rw_reg) begin
          eng_cmd      = CMD_READ;
          eng_cmd_last = (cnt_inc == len_reg);
        end else begin
          eng_cmd      = CMD_WRITE;
          eng_cmd_data = wdata_reg[DW-1 -: 8];
        end
      end
      ST_STOP: begin
        eng_cmd_valid = !wait_reg;
        eng_cmd       = CMD_STOP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      wait_reg  <= 1'b0;
      ptr_reg   <= IW'(N_REQ - 1);
      gnt_reg   <= '0;
      rw_reg    <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      tmr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            state_reg <= ST_START;
            wait_reg  <= 1'b0;
            gnt_reg   <= arb_oh;
            ptr_reg   <= arb_idx;
            rw_reg    <= req_rw[arb_idx];
            addr_reg  <= addr_arr[arb_idx];
            len_reg   <= arb_len;
            wdata_reg <= wdata_arr[arb_idx];
            rdata_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            tmr_reg   <= '0;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
        end
        default: begin
          if (xfer) begin
            wait_reg <= 1'b1;
            tmr_reg  <= '0;
          end else if (wait_reg && eng_rsp_valid) begin
            wait_reg <= 1'b0;
            tmr_reg  <= '0;
            case (state_reg)
              ST_START: state_reg <= ST_ADDR;
              ST_ADDR: begin
                if (eng_rsp_nack) begin
                  err_reg   <= 1'b1;
                  state_reg <= ST_STOP;
                end else begin
                  state_reg <= (len_reg == '0) ? ST_STOP : ST_DATA;
                end
              end
              ST_DATA: begin
                if (!rw_reg && eng_rsp_nack) begin
                  err_reg   <= 1'b1;
                  state_reg <= ST_STOP;
                end else begin
                  cnt_reg <= cnt_inc;
                  if (rw_reg) begin
                    for (int b = 0; b < MAX_BYTES; b++) begin
                      if (cnt_reg == LENW'(b)) rdata_reg[8*(MAX_BYTES-1-b) +: 8] <= eng_rsp_data;
                    end
                  end else begin
                    wdata_reg <= wdata_reg << 8;
                  end
                  if (cnt_inc == len_reg) state_reg <= ST_STOP;
                end
              end
              default: state_reg <= ST_RESP;
            endcase
          end else if (tmr_reg == TW'(TIMEOUT - 1)) begin
            // A stalled STOP cannot be retried, so finish the transaction directly.
            err_reg   <= 1'b1;
            wait_reg  <= 1'b0;
            tmr_reg   <= '0;
            state_reg <= (state_reg == ST_STOP) ? ST_RESP : ST_STOP;
          end else begin
            tmr_reg <= tmr_reg + TW'(1);
          end
        end
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_done  = (state_reg == ST_RESP) ? gnt_reg : '0;
  assign rsp_err   = (state_reg == ST_RESP && err_reg) ? gnt_reg : '0;
  assign rsp_rdata = rdata_reg;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler with a small behavioural engine model
// that logs every command transfer and every completion pulse.
module tb_i2c_txn_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  req_rw = '0;
  logic [13:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  gnt, rsp_done, rsp_err;
  logic [15:0] rsp_rdata;
  logic        busy, eng_cmd_valid, eng_cmd_last;
  logic [1:0]  eng_cmd;
  logic [7:0]  eng_cmd_data;
  logic        eng_cmd_ready = 1'b1;
  logic        eng_rsp_valid = 1'b0;
  logic [7:0]  eng_rsp_data = '0;
  logic        eng_rsp_nack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int   nack_idx = -1;
  bit   hold_read = 1'b0;
  bit   hold_stop = 1'b0;
  logic [7:0] rd_q[$];
  int   wr_cnt = 0;
  bit   pend = 1'b0;
  logic [7:0] pend_data = '0;
  logic pend_nack = 1'b0;

  logic [12:0] log_q[$];
  int          log_t[$];
  logic [3:0]  done_q[$];
  int          done_t[$];

  i2c_txn_scheduler #(.N_REQ(2), .MAX_BYTES(2), .LENW(2), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .rsp_done(rsp_done),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd(eng_cmd), .eng_cmd_data(eng_cmd_data),
    .eng_cmd_last(eng_cmd_last), .eng_cmd_ready(eng_cmd_ready),
    .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data), .eng_rsp_nack(eng_rsp_nack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Command entry: {gnt, cmd, last (READ only), data (WRITE only)}.
  function automatic logic [12:0] ent(logic [1:0] g, logic [1:0] c, logic l, logic [7:0] d);
    return {g, c, (c == 2'b10) ? l : 1'b0, (c == 2'b01) ? d : 8'h00};
  endfunction

  // Engine model: answers one cycle after each transfer unless told to withhold.
  always @(negedge clk) begin
    eng_rsp_valid = 1'b0;
    eng_rsp_nack  = 1'b0;
    eng_rsp_data  = 8'h00;
    if (rst) begin
      pend   = 1'b0;
      wr_cnt = 0;
    end else begin
      if (pend) begin
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = pend_data;
        eng_rsp_nack  = pend_nack;
        pend = 1'b0;
      end
      if (eng_cmd_valid && eng_cmd_ready) begin
        log_q.push_back(ent(gnt, eng_cmd, eng_cmd_last, eng_cmd_data));
        log_t.push_back(cyc);
        pend = 1'b1; pend_nack = 1'b0; pend_data = 8'h00;
        case (eng_cmd)
          2'b00: wr_cnt = 0;
          2'b01: begin pend_nack = (wr_cnt == nack_idx); wr_cnt++; end
          2'b10: begin
            if (hold_read) pend = 1'b0;
            else if (rd_q.size() > 0) pend_data = rd_q.pop_front();
          end
          default: if (hold_stop) pend = 1'b0;
        endcase
      end
      if (|rsp_done) begin
        done_q.push_back({rsp_done, rsp_err});
        done_t.push_back(cyc);
      end
    end
  end

  task automatic set_req(int i, bit rw, logic [6:0] a, logic [1:0] len, logic [15:0] wd);
    req_rw[i] = rw;
    req_addr[7*i +: 7] = a;
    req_len[2*i +: 2] = len;
    req_wdata[16*i +: 16] = wd;
  endtask

  task automatic clear_logs();
    log_q.delete(); log_t.delete(); done_q.delete(); done_t.delete();
  endtask

  task automatic wait_done(int n, int limit);
    for (int i = 0; i < limit && done_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
    checks++; if (eng_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", eng_cmd_valid); end
    checks++; if (rsp_done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", rsp_done); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", rsp_rdata); end
    $display("reset: busy=%b gnt=%b valid=%b", busy, gnt, eng_cmd_valid);
  endtask

  task automatic test_write();
    logic [12:0] exp[$];
    clear_logs();
    exp.push_back(ent(2'b01, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h0E));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'hA5));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h5A));
    exp.push_back(ent(2'b01, 2'b11, 0, 8'h00));
    set_req(0, 1'b0, 7'h07, 2'd2, 16'hA55A);
    req[0] = 1'b1;
    wait_done(1, 200);
    req[0] = 1'b0;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL write_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL write_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b0100) begin errors++; $display("FAIL write_done got n=%0d %h want 1 x 4", done_q.size(), (done_q.size() > 0) ? done_q[0] : 4'hx); end
    $display("write: cmds=%0d dones=%0d", log_q.size(), done_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    logic [12:0] exp[$];
    clear_logs();
    rd_q.delete(); rd_q.push_back(8'h3C); rd_q.push_back(8'hC3);
    exp.push_back(ent(2'b10, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b10, 2'b01, 0, 8'h0F));
    exp.push_back(ent(2'b10, 2'b10, 0, 8'h00));
    exp.push_back(ent(2'b10, 2'b10, 1, 8'h00));
    exp.push_back(ent(2'b10, 2'b11, 0, 8'h00));
    set_req(1, 1'b1, 7'h07, 2'd2, 16'h0000);
    req[1] = 1'b1;
    wait_done(1, 200);
    req[1] = 1'b0;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL read_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL read_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b1000) begin errors++; $display("FAIL read_done got n=%0d want 1 x 8", done_q.size()); end
    @(negedge clk);
    checks++; if (rsp_rdata !== 16'h3CC3) begin errors++; $display("FAIL read_rdata got %h want 3cc3", rsp_rdata); end
    $display("read: rdata=%h", rsp_rdata);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    set_req(0, 1'b0, 7'h07, 2'd0, 16'h0000);
    set_req(1, 1'b0, 7'h07, 2'd0, 16'h0000);
    req = 2'b11;
    wait_done(3, 300);
    req = 2'b00;
    checks++; if (done_q.size() != 3) begin errors++; $display("FAIL rr_count got %0d want 3", done_q.size()); end
    else begin
      checks++; if (done_q[0] !== 4'b0100) begin errors++; $display("FAIL rr_first got %h want 4", done_q[0]); end
      checks++; if (done_q[1] !== 4'b1000) begin errors++; $display("FAIL rr_second got %h want 8", done_q[1]); end
      checks++; if (done_q[2] !== 4'b0100) begin errors++; $display("FAIL rr_third got %h want 4", done_q[2]); end
    end
    $display("round_robin: dones=%0d", done_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nack();
    logic [12:0] exp[$];
    clear_logs();
    nack_idx = 0;
    exp.push_back(ent(2'b01, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h2A));
    exp.push_back(ent(2'b01, 2'b11, 0, 8'h00));
    set_req(0, 1'b0, 7'h15, 2'd2, 16'h1122);
    req[0] = 1'b1;
    wait_done(1, 200);
    req[0] = 1'b0;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL nack_addr_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL nack_addr_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b0101) begin errors++; $display("FAIL nack_addr_done got n=%0d want 1 x 5", done_q.size()); end
    $display("nack_addr: cmds=%0d", log_q.size());
    repeat (2) @(negedge clk);

    clear_logs();
    nack_idx = 1;
    exp.delete();
    exp.push_back(ent(2'b01, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h2A));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h11));
    exp.push_back(ent(2'b01, 2'b11, 0, 8'h00));
    req[0] = 1'b1;
    wait_done(1, 200);
    req[0] = 1'b0;
    nack_idx = -1;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL nack_data_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL nack_data_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b0101) begin errors++; $display("FAIL nack_data_done got n=%0d want 1 x 5", done_q.size()); end
    $display("nack_data: cmds=%0d", log_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [12:0] exp[$];
    int d;
    clear_logs();
    hold_read = 1'b1;
    hold_stop = 1'b1;
    exp.push_back(ent(2'b10, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b10, 2'b01, 0, 8'h0F));
    exp.push_back(ent(2'b10, 2'b10, 0, 8'h00));
    exp.push_back(ent(2'b10, 2'b11, 0, 8'h00));
    set_req(1, 1'b1, 7'h07, 2'd2, 16'h0000);
    req[1] = 1'b1;
    wait_done(1, 500);
    req[1] = 1'b0;
    hold_read = 1'b0;
    hold_stop = 1'b0;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL tmo_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL tmo_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b1010) begin errors++; $display("FAIL tmo_done got n=%0d want 1 x a", done_q.size()); end
    if (log_t.size() == 4 && done_t.size() == 1) begin
      d = log_t[3] - log_t[2];
      checks++; if (d < 100 || d > 102) begin errors++; $display("FAIL tmo_read_gap got %0d want 100..102", d); end
      d = done_t[0] - log_t[3];
      checks++; if (d < 100 || d > 102) begin errors++; $display("FAIL tmo_stop_gap got %0d want 100..102", d); end
    end
    @(negedge clk);
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL tmo_rdata got %h want 0000", rsp_rdata); end
    $display("timeout: cmds=%0d", log_q.size());
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [12:0] exp[$];
    int stops;
    clear_logs();
    set_req(0, 1'b0, 7'h07, 2'd2, 16'h1234);
    req[0] = 1'b1;
    for (int i = 0; i < 100 && log_q.size() < 3; i++) @(negedge clk);
    checks++; if (log_q.size() < 3) begin errors++; $display("FAIL rst_reach_data got %0d want 3", log_q.size()); end
    req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", gnt); end
    checks++; if (eng_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", eng_cmd_valid); end
    checks++; if (rsp_done !== 2'b00) begin errors++; $display("FAIL rst_done got %b want 00", rsp_done); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    stops = 0;
    foreach (log_q[i]) if (log_q[i][10:9] == 2'b11) stops++;
    checks++; if (stops != 0) begin errors++; $display("FAIL rst_no_stop got %0d want 0", stops); end

    clear_logs();
    exp.push_back(ent(2'b01, 2'b00, 0, 8'h00));
    exp.push_back(ent(2'b01, 2'b01, 0, 8'h0E));
    exp.push_back(ent(2'b01, 2'b11, 0, 8'h00));
    set_req(0, 1'b0, 7'h07, 2'd0, 16'h0000);
    req[0] = 1'b1;
    wait_done(1, 200);
    req[0] = 1'b0;
    checks++; if (log_q.size() != exp.size()) begin errors++; $display("FAIL len0_ncmd got %0d want %0d", log_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      checks++; if (log_q[i] !== exp[i]) begin errors++; $display("FAIL len0_cmd%0d got %h want %h", i, log_q[i], exp[i]); end
    end
    checks++; if (done_q.size() != 1 || done_q[0] !== 4'b0100) begin errors++; $display("FAIL len0_done got n=%0d want 1 x 4", done_q.size()); end
    $display("rst_mid: cmds_after=%0d", log_q.size());
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_nack();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
